gpr_file: RTL and testbench



---
 rtl/gpr_file.sv | 86 ++++++++
 tb/tb_gpr_file.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/gpr_file.sv
// General-purpose register file: two combinational read ports with write-through bypass,
// one write port, r0 hardwired to zero, and a post-reset sequencer that clears r1..r(N-1).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | clearing mem[clr_ptr] each cycle; writes ignored, reads 0
// ST_READY | normal operation; left only via reset
module gpr_file #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int INIT_CLEAR = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr_0,
   output logic [DATA_W-1:0] rd_data_0,
   input  logic [ADDR_W-1:0] rd_addr_1,
   output logic [DATA_W-1:0] rd_data_1,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              we_,
   output logic              init_busy
);

   localparam int NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS-1);

   typedef enum logic {ST_INIT, ST_READY} state_t;
   localparam state_t RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_READY;

   state_t            state, state_nxt;
   logic [ADDR_W:0]   clr_ptr, clr_ptr_nxt;
   logic [DATA_W-1:0] mem [NUM_REGS];
   logic              wr_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= RST_STATE;
         clr_ptr <= (ADDR_W+1)'(1);
      end else begin
         state   <= state_nxt;
         clr_ptr <= clr_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_ptr_nxt = clr_ptr;
      case (state)
         ST_INIT: begin
            clr_ptr_nxt = clr_ptr + (ADDR_W+1)'(1);
            if (clr_ptr == LAST_IDX) state_nxt = ST_READY;
         end
         default: state_nxt = ST_READY;
      endcase
   end

   // init_busy comes straight off the state flop, so it is glitch-free for the stall logic
   assign init_busy = (state == ST_INIT);
   assign wr_en     = (state == ST_READY) && !we_ && (wr_addr != '0);

   // Storage has no reset; the clear sequence zeroes it instead
   always_ff @(posedge clk) begin
      if (state == ST_INIT)
         mem[clr_ptr[ADDR_W-1:0]] <= '0;
      else if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] val;
      if (!reset || addr == '0 || state == ST_INIT)
         val = '0;
      else if (!we_ && wr_addr == addr)
         val = wr_data;
      else
         val = mem[addr];
      return val;
   endfunction

   always_comb begin
      rd_data_0 = rd_mux(rd_addr_0);
      rd_data_1 = rd_mux(rd_addr_1);
   end

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed scenarios plus random traffic checked
// against an array-based reference model of the register file.
`timescale 1ns/1ps
module tb_gpr_file;

   logic        clk;
   logic        reset;
   logic [4:0]  rd_addr_0, rd_addr_1, wr_addr;
   logic [31:0] rd_data_0, rd_data_1, wr_data;
   logic        we_;
   logic        init_busy;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [31:0] ref_mem [32];
   bit          ref_ready;
   int          ref_rem;

   gpr_file #(.DATA_W(32), .ADDR_W(5), .INIT_CLEAR(1)) dut (
      .clk(clk), .reset(reset),
      .rd_addr_0(rd_addr_0), .rd_data_0(rd_data_0),
      .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1),
      .wr_addr(wr_addr), .wr_data(wr_data), .we_(we_),
      .init_busy(init_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_read(input logic [4:0] a);
      if (a == 5'd0 || !ref_ready) return 32'h0;
      if (!we_ && wr_addr == a) return wr_data;
      return ref_mem[a];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      assert (got === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
   endtask

   task automatic ref_start_init();
      ref_ready = 1'b0;
      ref_rem   = 31;
   endtask

   task automatic ref_edge();
      if (ref_ready) begin
         if (!we_ && wr_addr != 5'd0) ref_mem[wr_addr] = wr_data;
      end else begin
         ref_rem--;
         if (ref_rem == 0) begin
            ref_ready = 1'b1;
            for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
         end
      end
   endtask

   // Drive one cycle of inputs, check combinational outputs before the edge, advance model.
   task automatic step(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] wa, input logic [31:0] wd, input logic w_n);
      rd_addr_0 = a0; rd_addr_1 = a1; wr_addr = wa; wr_data = wd; we_ = w_n;
      #2;
      chk({tag, ".busy"}, {31'h0, init_busy}, {31'h0, !ref_ready});
      chk({tag, ".rd0"}, rd_data_0, ref_read(a0));
      chk({tag, ".rd1"}, rd_data_1, ref_read(a1));
      @(posedge clk);
      ref_edge();
      @(negedge clk);
   endtask

   task automatic idle(input string tag, input logic [4:0] a0, input logic [4:0] a1);
      step(tag, a0, a1, 5'($urandom_range(0, 31)), $urandom, 1'b1);
   endtask

   initial begin
      reset = 1'b0; we_ = 1'b1; wr_addr = '0; wr_data = '0; rd_addr_0 = 5'd5; rd_addr_1 = 5'd9;
      ref_ready = 1'b0; ref_rem = 31;
      #12;
      chk("rst.busy", {31'h0, init_busy}, 32'h1);
      chk("rst.rd0", rd_data_0, 32'h0);
      chk("rst.rd1", rd_data_1, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      ref_start_init();

      // Initial clear: busy for exactly 31 cycles, writes ignored
      for (int i = 0; i < 31; i++)
         step("init", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      for (int i = 1; i < 32; i += 2)
         idle("clear", 5'(i), 5'((i + 1) % 32));

      // Write-through bypass, then held value
      step("byp", 5'd5, 5'd5, 5'd5, 32'hDEADBEEF, 1'b0);
      idle("held", 5'd5, 5'd0);
      chk("held.val", ref_mem[5], 32'hDEADBEEF);

      // r0 stays zero
      step("r0w", 5'd0, 5'd0, 5'd0, 32'h1234, 1'b0);
      idle("r0r", 5'd0, 5'd0);

      // Dual read, same address on both ports
      step("w7", 5'd1, 5'd2, 5'd7, 32'hA5A5_0000, 1'b0);
      step("w8", 5'd7, 5'd8, 5'd8, 32'h0000_5A5A, 1'b0);
      idle("r78", 5'd7, 5'd8);
      idle("r88", 5'd8, 5'd8);

      // Random traffic
      for (int i = 0; i < 80; i++)
         step("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));

      // Reset pulse mid-stream: clear repeats, write during INIT discarded
      step("w3", 5'd3, 5'd0, 5'd3, 32'h1, 1'b0);
      idle("r3", 5'd3, 5'd31);
      reset = 1'b0;
      #1;
      chk("pulse.busy", {31'h0, init_busy}, 32'h1);
      chk("pulse.rd0", rd_data_0, 32'h0);
      #2;
      reset = 1'b1;
      ref_start_init();
      @(posedge clk);
      ref_edge();
      @(negedge clk);
      for (int i = 2; i <= 31; i++) begin
         if (i == 10) step("init_wr", 5'd31, 5'd3, 5'd31, 32'hFFFF_FFFF, 1'b0);
         else idle("reinit", 5'd31, 5'd3);
      end
      idle("post", 5'd31, 5'd3);
      chk("post.r3", ref_mem[3], 32'h0);
      idle("post2", 5'd31, 5'd3);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
